// File: rtl/demux4_reg_if.sv
// Handshake bundle for demux4_reg: one valid/ready input stream steered to four
// registered output slots, each with its own valid/ready pair.
interface demux4_reg_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNTW  = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_sel;
    logic [WIDTH-1:0] in_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] o0;
    logic [WIDTH-1:0] o1;
    logic [WIDTH-1:0] o2;
    logic [WIDTH-1:0] o3;
    logic [CNTW-1:0]  xfer_cnt;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, o0, o1, o2, o3, xfer_cnt
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, o0, o1, o2, o3, xfer_cnt
    );
endinterface

// File: rtl/demux4_reg.sv
// Registered 1-to-4 stream demultiplexer: each accepted word lands in the slot chosen by
// in_sel and is held there until that slot's consumer takes it.
module demux4_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNTW  = 8
) (
    input logic         clk,
    input logic         rst,
    demux4_reg_if.slave bus
);
    typedef enum logic {StEmpty, StFull} slot_st_e;

    slot_st_e         st_q   [4];
    logic [WIDTH-1:0] data_q [4];
    logic [CNTW-1:0]  cnt_q;
    logic [CNTW-1:0]  cnt_d;
    logic [3:0]       full;
    logic [3:0]       sel_oh;
    logic [3:0]       load;
    logic [3:0]       drain;
    logic             in_ready;
    logic             accept;

    always_comb begin
        sel_oh = 4'b0000;
        unique case (bus.in_sel)
            2'd0: sel_oh = 4'b0001;
            2'd1: sel_oh = 4'b0010;
            2'd2: sel_oh = 4'b0100;
            2'd3: sel_oh = 4'b1000;
        endcase
        for (int k = 0; k < 4; k++) begin
            full[k] = (st_q[k] == StFull);
        end
        // Only the addressed slot gates ready; a slot being drained can refill in the same cycle.
        in_ready = ~rst & (~full[bus.in_sel] | bus.out_ready[bus.in_sel]);
        accept   = bus.in_valid & in_ready;
        load     = sel_oh & {4{accept}};
        drain    = full & bus.out_ready;
        cnt_d    = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            for (int k = 0; k < 4; k++) begin
                st_q[k]   <= StEmpty;
                data_q[k] <= '0;
            end
        end else begin
            if (accept) begin
                cnt_q <= cnt_d;
            end
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    st_q[k]   <= StFull;
                    data_q[k] <= bus.in_data;
                end else if (drain[k]) begin
                    st_q[k]   <= StEmpty;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = full;
    assign bus.o0        = data_q[0];
    assign bus.o1        = data_q[1];
    assign bus.o2        = data_q[2];
    assign bus.o3        = data_q[3];
    assign bus.xfer_cnt  = cnt_q;
endmodule

// File: tb/tb_demux4_reg.sv
// Bench for demux4_reg: directed scenario tasks plus a negedge scoreboard that tracks
// per-slot expected words, slot occupancy, ready and the accept counter.
module tb_demux4_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;

    demux4_reg_if #(.WIDTH(8), .CNTW(8)) bus ();

    demux4_reg #(.WIDTH(8), .CNTW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb [4][$];
    logic [3:0] m_full = 4'b0000;
    logic [7:0] m_cnt  = 8'd0;

    function automatic logic [7:0] odata(input int k);
        case (k)
            0:       return bus.o0;
            1:       return bus.o1;
            2:       return bus.o2;
            default: return bus.o3;
        endcase
    endfunction

    // Scoreboard: inputs are stable at negedge, so decide here what the next edge does.
    always @(negedge clk) begin
        logic exp_ready;
        if (rst) begin
            m_full = 4'b0000;
            m_cnt  = 8'd0;
            for (int k = 0; k < 4; k++) sb[k].delete();
        end else begin
            exp_ready = !m_full[bus.in_sel] || bus.out_ready[bus.in_sel];
            checks++;
            if (bus.in_ready !== exp_ready) begin
                failures++;
                $display("FAIL sb_in_ready: got %b expected %b", bus.in_ready, exp_ready);
            end
            checks++;
            if (bus.out_valid !== m_full) begin
                failures++;
                $display("FAIL sb_out_valid: got %b expected %b", bus.out_valid, m_full);
            end
            checks++;
            if (bus.xfer_cnt !== m_cnt) begin
                failures++;
                $display("FAIL sb_xfer_cnt: got %0d expected %0d", bus.xfer_cnt, m_cnt);
            end
            for (int k = 0; k < 4; k++) begin
                if (m_full[k] && sb[k].size() > 0) begin
                    checks++;
                    if (odata(k) !== sb[k][0]) begin
                        failures++;
                        $display("FAIL sb_data slot%0d: got %h expected %h", k, odata(k),
                                 sb[k][0]);
                    end
                    if (bus.out_ready[k]) begin
                        void'(sb[k].pop_front());
                        m_full[k] = 1'b0;
                    end
                end
            end
            if (bus.in_valid && exp_ready) begin
                sb[bus.in_sel].push_back(bus.in_data);
                m_full[bus.in_sel] = 1'b1;
                m_cnt = m_cnt + 8'd1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b1111;
        cyc();
        cyc();
        bus.out_ready = 4'b0000;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd0;
        bus.in_data   = 8'h00;
        bus.out_ready = 4'b0000;
        cyc();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 4'b0000 || bus.xfer_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_state: got valid=%b cnt=%0d expected 0000/0", bus.out_valid,
                     bus.xfer_cnt);
        end
        checks++;
        if ({bus.o0, bus.o1, bus.o2, bus.o3} !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: got %h%h%h%h expected 0", bus.o0, bus.o1, bus.o2, bus.o3);
        end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_steer();
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd2;
        bus.in_data   = 8'hA5;
        bus.out_ready = 4'b0000;
        cyc();
        checks++;
        if (bus.out_valid !== 4'b0100 || bus.o2 !== 8'hA5 || bus.xfer_cnt !== 8'd1) begin
            failures++;
            $display("FAIL steer: got valid=%b o2=%h cnt=%0d expected 0100/a5/1", bus.out_valid,
                     bus.o2, bus.xfer_cnt);
        end
        bus.in_data = 8'h5A;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL steer_block: got in_ready=%b expected 0", bus.in_ready);
        end
        cyc();
        checks++;
        if (bus.o2 !== 8'hA5 || bus.out_valid !== 4'b0100 || bus.xfer_cnt !== 8'd1) begin
            failures++;
            $display("FAIL steer_hold: got o2=%h valid=%b cnt=%0d expected a5/0100/1", bus.o2,
                     bus.out_valid, bus.xfer_cnt);
        end
        idle();
    endtask

    task automatic test_fill_drain();
        int acc = 0;
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd0;
        bus.in_data  = 8'h11;
        cyc();
        bus.out_ready = 4'b0001;
        bus.in_data   = 8'h22;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL fwd_ready: got %b expected 1", bus.in_ready);
        end
        cyc();
        checks++;
        if (bus.o0 !== 8'h22 || bus.out_valid[0] !== 1'b1) begin
            failures++;
            $display("FAIL fwd_data: got o0=%h v=%b expected 22/1", bus.o0, bus.out_valid[0]);
        end
        for (int i = 0; i < 8; i++) begin
            bus.in_data = 8'h30 + 8'(i);
            #1;
            if (bus.in_ready) acc++;
            cyc();
        end
        checks++;
        if (acc != 8) begin
            failures++;
            $display("FAIL fwd_stream: got %0d accepts expected 8", acc);
        end
        idle();
    endtask

    task automatic test_isolation();
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd1;
        bus.in_data   = 8'h55;
        cyc();
        bus.in_sel  = 2'd3;
        bus.in_data = 8'h77;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL iso_ready: got %b expected 1", bus.in_ready);
        end
        cyc();
        checks++;
        if (bus.o1 !== 8'h55 || bus.o3 !== 8'h77 || bus.out_valid !== 4'b1010) begin
            failures++;
            $display("FAIL iso_slots: got o1=%h o3=%h valid=%b expected 55/77/1010", bus.o1,
                     bus.o3, bus.out_valid);
        end
        idle();
    endtask

    task automatic test_multi_drain();
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.in_sel  = 2'(k);
            bus.in_data = 8'((k + 1) * 16);
            cyc();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b1111;
        cyc();
        checks++;
        if (bus.out_valid !== 4'b0000) begin
            failures++;
            $display("FAIL mdrain_valid: got %b expected 0000", bus.out_valid);
        end
        checks++;
        if ({bus.o0, bus.o1, bus.o2, bus.o3} !== 32'h10203040) begin
            failures++;
            $display("FAIL mdrain_data: got %h%h%h%h expected 10203040", bus.o0, bus.o1,
                     bus.o2, bus.o3);
        end
        bus.out_ready = 4'b0000;
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd1;
        bus.in_data   = 8'hC1;
        cyc();
        bus.in_sel  = 2'd3;
        bus.in_data = 8'hC3;
        cyc();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 4'b0000 || bus.xfer_cnt !== 8'd0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: got valid=%b cnt=%0d rdy=%b expected 0000/0/0",
                     bus.out_valid, bus.xfer_cnt, bus.in_ready);
        end
        checks++;
        if ({bus.o0, bus.o1, bus.o2, bus.o3} !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid_data: got %h%h%h%h expected 0", bus.o0, bus.o1, bus.o2,
                     bus.o3);
        end
        cyc();
        rst         = 1'b0;
        bus.in_sel  = 2'd0;
        bus.in_data = 8'h5A;
        cyc();
        checks++;
        if (bus.out_valid !== 4'b0001 || bus.o0 !== 8'h5A || bus.xfer_cnt !== 8'd1) begin
            failures++;
            $display("FAIL rst_first_accept: got valid=%b o0=%h cnt=%0d expected 0001/5a/1",
                     bus.out_valid, bus.o0, bus.xfer_cnt);
        end
        idle();
    endtask

    task automatic test_wrap();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst           = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 4'b1111;
        for (int i = 0; i < 256; i++) begin
            bus.in_sel  = 2'(i);
            bus.in_data = 8'(i);
            if (i == 255) begin
                checks++;
                if (bus.xfer_cnt !== 8'hFF) begin
                    failures++;
                    $display("FAIL wrap_pre: got %0d expected 255", bus.xfer_cnt);
                end
            end
            cyc();
        end
        checks++;
        if (bus.xfer_cnt !== 8'd0) begin
            failures++;
            $display("FAIL wrap: got %0d expected 0", bus.xfer_cnt);
        end
        idle();
    endtask

    task automatic test_random();
        logic hold = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_sel   = 2'($urandom_range(0, 3));
                bus.in_data  = 8'($urandom);
            end
            bus.out_ready = 4'($urandom);
            #1;
            hold = bus.in_valid && !bus.in_ready;
            cyc();
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (sb[k].size() != 0 || bus.out_valid[k] !== 1'b0) begin
                failures++;
                $display("FAIL rand_leftover slot%0d: got %0d queued v=%b expected 0/0", k,
                         sb[k].size(), bus.out_valid[k]);
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = 8'h00;
        bus.out_ready = 4'b0000;
        cyc();
        test_reset();
        test_steer();
        test_fill_drain();
        test_isolation();
        test_multi_drain();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
